// File: rtl/ahb_slave_port_mux.sv
// Per-slave AHB port mux: registers address/data-phase ownership from the arbiter grant,
// muxes the owning master onto the slave, routes the response back and tracks burst beats.
module ahb_slave_port_mux #(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                         hclk,
  input  logic                         hreset_n,
  input  logic [MASTER_NUM-1:0]        hgrant,
  input  logic [MASTER_NUM*ADDR_W-1:0] haddr_m,
  input  logic [2*MASTER_NUM-1:0]      htrans_m,
  input  logic [MASTER_NUM-1:0]        hwrite_m,
  input  logic [3*MASTER_NUM-1:0]      hsize_m,
  input  logic [3*MASTER_NUM-1:0]      hburst_m,
  input  logic [MASTER_NUM*DATA_W-1:0] hwdata_m,
  input  logic                         hready_s,
  input  logic                         hresp_s,
  input  logic [DATA_W-1:0]            hrdata_s,
  output logic [ADDR_W-1:0]            haddr_s,
  output logic [1:0]                   htrans_s,
  output logic                         hwrite_s,
  output logic [2:0]                   hsize_s,
  output logic [2:0]                   hburst_s,
  output logic [DATA_W-1:0]            hwdata_s,
  output logic [MASTER_NUM-1:0]        hready_m,
  output logic [MASTER_NUM-1:0]        hresp_m,
  output logic [DATA_W-1:0]            hrdata_m,
  output logic                         hwait,
  output logic                         burst_last,
  output logic                         grant_err
);

  localparam logic [1:0] TransIdle   = 2'd0;
  localparam logic [1:0] TransNonseq = 2'd2;
  localparam logic [1:0] TransSeq    = 2'd3;

  typedef enum logic [1:0] {StIdle, StBurst, StErr} state_e;

  state_e                state_q, state_d;
  logic [MASTER_NUM-1:0] addr_sel_q, data_sel_q;
  logic                  data_valid_q;
  logic [3:0]            count_q, count_d;
  logic [3:0]            limit_q, limit_d;
  logic                  grant_err_q;

  logic [MASTER_NUM-1:0] grant_low;
  logic                  grant_multi;
  logic                  grant_found;
  logic [1:0]            trans_sel;
  logic                  first_err;
  logic                  force_idle;
  logic                  nonseq_acc, seq_acc, owner_change;
  logic [3:0]            burst_limit;

  // Reduce the grant to its lowest set bit and flag multi-hot grants.
  always_comb begin
    grant_low   = '0;
    grant_multi = 1'b0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (hgrant[i]) begin
        if (grant_found) grant_multi = 1'b1;
        else             grant_low[i] = 1'b1;
        grant_found = 1'b1;
      end
    end
  end

  // First ERROR cycle and the ERR cycle after it cancel any transfer presented to the slave.
  assign first_err  = hresp_s & ~hready_s;
  assign force_idle = first_err | (state_q == StErr);

  // Address/control mux from the address-phase owner.
  always_comb begin
    haddr_s   = '0;
    trans_sel = TransIdle;
    hwrite_s  = 1'b0;
    hsize_s   = '0;
    hburst_s  = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (addr_sel_q[i]) begin
        haddr_s   = haddr_m[i*ADDR_W +: ADDR_W];
        trans_sel = htrans_m[2*i +: 2];
        hwrite_s  = hwrite_m[i];
        hsize_s   = hsize_m[3*i +: 3];
        hburst_s  = hburst_m[3*i +: 3];
      end
    end
    htrans_s = force_idle ? TransIdle : trans_sel;
  end

  // Write data from the data-phase owner, response routed back to it only.
  always_comb begin
    hwdata_s = '0;
    hresp_m  = '0;
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      if (data_valid_q && data_sel_q[i]) begin
        hwdata_s   = hwdata_m[i*DATA_W +: DATA_W];
        hresp_m[i] = hresp_s;
      end
    end
  end

  assign hready_m  = {MASTER_NUM{hready_s}};
  assign hrdata_m  = hrdata_s;
  assign hwait     = ~hready_s;
  assign grant_err = grant_err_q;

  assign nonseq_acc   = hready_s && (htrans_s == TransNonseq);
  assign seq_acc      = hready_s && (htrans_s == TransSeq);
  assign owner_change = hready_s && (grant_low != addr_sel_q);

  // Beat limit (beats minus one) for fixed-length bursts; zero means undefined length.
  always_comb begin
    case (hburst_s)
      3'd2, 3'd3: burst_limit = 4'd3;
      3'd4, 3'd5: burst_limit = 4'd7;
      3'd6, 3'd7: burst_limit = 4'd15;
      default:    burst_limit = 4'd0;
    endcase
  end

  // Beat FSM next state and burst_last pulse.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    burst_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (nonseq_acc && (burst_limit != 4'd0)) begin
          limit_d = burst_limit;
          count_d = 4'd0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (seq_acc && (count_q == limit_q - 4'd1)) begin
          burst_last = 1'b1;
          state_d    = StIdle;
        end else if (owner_change) begin
          state_d = StIdle;
        end else if (nonseq_acc) begin
          if (burst_limit != 4'd0) begin
            limit_d = burst_limit;
            count_d = 4'd0;
          end else begin
            state_d = StIdle;
          end
        end else if (seq_acc) begin
          count_d = count_q + 4'd1;
        end
      end
      StErr: begin
        state_d = StIdle;
        count_d = 4'd0;
      end
      default: state_d = StIdle;
    endcase
    if (first_err) begin
      state_d    = StErr;
      burst_last = 1'b0;
    end
  end

  // Ownership, beat counter and sticky grant error registers.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q      <= StIdle;
      addr_sel_q   <= '0;
      data_sel_q   <= '0;
      data_valid_q <= 1'b0;
      count_q      <= '0;
      limit_q      <= '0;
      grant_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      if (hready_s) begin
        addr_sel_q   <= grant_low;
        data_sel_q   <= addr_sel_q;
        data_valid_q <= htrans_s[1];
        if (grant_multi) grant_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Self-checking bench for ahb_slave_port_mux: directed scenarios plus a random phase,
// every cycle compared against a transaction-level reference model.
module tb_ahb_slave_port_mux;

  localparam int unsigned MN = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic             hclk = 1'b0;
  logic             hreset_n;
  logic [MN-1:0]    hgrant;
  logic [MN*AW-1:0] haddr_m;
  logic [2*MN-1:0]  htrans_m;
  logic [MN-1:0]    hwrite_m;
  logic [3*MN-1:0]  hsize_m;
  logic [3*MN-1:0]  hburst_m;
  logic [MN*DW-1:0] hwdata_m;
  logic             hready_s;
  logic             hresp_s;
  logic [DW-1:0]    hrdata_s;
  logic [AW-1:0]    haddr_s;
  logic [1:0]       htrans_s;
  logic             hwrite_s;
  logic [2:0]       hsize_s;
  logic [2:0]       hburst_s;
  logic [DW-1:0]    hwdata_s;
  logic [MN-1:0]    hready_m;
  logic [MN-1:0]    hresp_m;
  logic [DW-1:0]    hrdata_m;
  logic             hwait;
  logic             burst_last;
  logic             grant_err;

  ahb_slave_port_mux #(.MASTER_NUM(MN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk       (hclk),
    .hreset_n   (hreset_n),
    .hgrant     (hgrant),
    .haddr_m    (haddr_m),
    .htrans_m   (htrans_m),
    .hwrite_m   (hwrite_m),
    .hsize_m    (hsize_m),
    .hburst_m   (hburst_m),
    .hwdata_m   (hwdata_m),
    .hready_s   (hready_s),
    .hresp_s    (hresp_s),
    .hrdata_s   (hrdata_s),
    .haddr_s    (haddr_s),
    .htrans_s   (htrans_s),
    .hwrite_s   (hwrite_s),
    .hsize_s    (hsize_s),
    .hburst_s   (hburst_s),
    .hwdata_s   (hwdata_s),
    .hready_m   (hready_m),
    .hresp_m    (hresp_m),
    .hrdata_m   (hrdata_m),
    .hwait      (hwait),
    .burst_last (burst_last),
    .grant_err  (grant_err)
  );

  always #5 hclk = ~hclk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: owner indices (-1 = none), burst beats still to come, error window.
  int m_a, m_d, m_rem;
  bit m_dv, m_gerr, m_inb, m_errp;
  bit bl_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [MN-1:0] g);
    for (int i = 0; i < int'(MN); i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic bit in_err_window();
    return (hresp_s && !hready_s) || m_errp;
  endfunction

  function automatic logic [1:0] exp_trans();
    if (m_a < 0 || in_err_window()) return 2'd0;
    return htrans_m[2*m_a +: 2];
  endfunction

  function automatic logic [2:0] exp_burst();
    if (m_a < 0) return 3'd0;
    return hburst_m[3*m_a +: 3];
  endfunction

  task automatic check_all();
    logic [31:0] ea, ew;
    logic [2:0]  es;
    logic        ewr, ebl;
    logic [MN-1:0] er;
    ea = '0; es = '0; ewr = 1'b0; ew = '0; er = '0;
    if (m_a >= 0) begin
      ea  = haddr_m[m_a*AW +: AW];
      es  = hsize_m[3*m_a +: 3];
      ewr = hwrite_m[m_a];
    end
    if (m_dv) begin
      ew = hwdata_m[m_d*DW +: DW];
      er[m_d] = hresp_s;
    end
    ebl = m_inb && !m_errp && hready_s && (exp_trans() == 2'd3) && (m_rem == 1);
    chk("haddr_s", haddr_s, ea);
    chk("htrans_s", 32'(htrans_s), 32'(exp_trans()));
    chk("hwrite_s", 32'(hwrite_s), 32'(ewr));
    chk("hsize_s", 32'(hsize_s), 32'(es));
    chk("hburst_s", 32'(hburst_s), 32'(exp_burst()));
    chk("hwdata_s", hwdata_s, ew);
    chk("hresp_m", 32'(hresp_m), 32'(er));
    chk("hready_m", 32'(hready_m), 32'({MN{hready_s}}));
    chk("hrdata_m", hrdata_m, hrdata_s);
    chk("hwait", 32'(hwait), 32'(!hready_s));
    chk("burst_last", 32'(burst_last), 32'(ebl));
    chk("grant_err", 32'(grant_err), 32'(m_gerr));
    bl_seen = burst_last;
  endtask

  // Advance the model across one clock edge using the inputs sampled at that edge.
  task automatic model_edge();
    logic [1:0] t;
    int len, new_a, cnt;
    if (!hreset_n) begin
      m_a = -1; m_d = -1; m_dv = 0; m_gerr = 0; m_inb = 0; m_errp = 0; m_rem = 0;
      return;
    end
    t     = exp_trans();
    len   = (exp_burst() >= 3'd2) ? (2 << (exp_burst() >> 1)) : 1;
    new_a = lowest(hgrant);
    cnt   = $countones(hgrant);
    if (hresp_s && !hready_s) begin
      m_errp = 1; m_inb = 0;
    end else if (m_errp) begin
      m_errp = 0; m_inb = 0;
    end else if (m_inb) begin
      if (hready_s) begin
        if (t == 2'd3 && m_rem == 1) m_inb = 0;
        else if (new_a != m_a) m_inb = 0;
        else if (t == 2'd2) begin
          if (len > 1) m_rem = len - 1;
          else m_inb = 0;
        end else if (t == 2'd3) m_rem--;
      end
    end else if (hready_s && t == 2'd2 && len > 1) begin
      m_inb = 1; m_rem = len - 1;
    end
    if (hready_s) begin
      if (cnt > 1) m_gerr = 1;
      m_d  = m_a;
      m_dv = t[1];
      m_a  = new_a;
    end
  endtask

  // Inputs change 1 ns after the edge; checks land on the falling edge.
  task automatic tick_chk();
    hrdata_s = $urandom();
    #4;
    check_all();
  endtask

  task automatic tick_edge();
    @(posedge hclk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    tick_chk();
    tick_edge();
  endtask

  task automatic set_m(input int i, input logic [1:0] tr, input logic [2:0] bu,
                       input logic [31:0] ad);
    haddr_m[i*AW +: AW]  = ad;
    htrans_m[2*i +: 2]   = tr;
    hburst_m[3*i +: 3]   = bu;
    hsize_m[3*i +: 3]    = 3'd2;
    hwrite_m[i]          = 1'b1;
    hwdata_m[i*DW +: DW] = $urandom();
  endtask

  task automatic idle_all();
    htrans_m = '0;
  endtask

  task automatic run_burst(input int m, input logic [2:0] bu, input int n, input int wait_at,
                           input int wait_len, output int pulses, output int last_beat);
    idle_all();
    hgrant = '0; hgrant[m] = 1'b1;
    hready_s = 1'b1; hresp_s = 1'b0;
    tick();
    pulses = 0; last_beat = 0;
    for (int b = 0; b < n; b++) begin
      set_m(m, (b == 0) ? 2'd2 : 2'd3, bu, 32'h1000 * (m + 1) + 32'(b * 4));
      if (b == wait_at) begin
        for (int k = 0; k < wait_len; k++) begin
          hready_s = 1'b0;
          tick_chk();
          if (bl_seen) pulses++;
          chk("hwait_stall", 32'(hwait), 32'd1);
          tick_edge();
        end
      end
      hready_s = 1'b1;
      tick_chk();
      if (bl_seen) begin pulses++; last_beat = b + 1; end
      tick_edge();
    end
    idle_all();
    tick_chk();
    if (bl_seen) pulses++;
    tick_edge();
  endtask

  initial begin
    int pulses, last_beat;
    logic [31:0] wd;
    m_a = -1; m_d = -1; m_dv = 0; m_gerr = 0; m_inb = 0; m_errp = 0; m_rem = 0;
    hreset_n = 1'b0; hgrant = '0; haddr_m = '0; htrans_m = '0; hwrite_m = '0;
    hsize_m = '0; hburst_m = '0; hwdata_m = '0; hready_s = 1'b1; hresp_s = 1'b0;
    hrdata_s = '0;
    @(posedge hclk);
    model_edge();
    #1;
    tick();
    chk("reset_haddr", haddr_s, 32'd0);
    chk("reset_htrans", 32'(htrans_s), 32'd0);
    hreset_n = 1'b1;
    tick();

    // Grant master0, single NONSEQ write, data phase follows one cycle later.
    hgrant = 2'b01;
    tick();
    set_m(0, 2'd2, 3'd0, 32'hA000_0000);
    wd = hwdata_m[31:0];
    tick_chk();
    chk("m0_haddr", haddr_s, 32'hA000_0000);
    chk("m0_nonseq", 32'(htrans_s), 32'd2);
    tick_edge();
    htrans_m[1:0] = 2'd0;
    tick_chk();
    chk("m0_hwdata", hwdata_s, wd);
    tick_edge();

    // INCR4 from master1, no waits.
    run_burst(1, 3'd3, 4, -1, 0, pulses, last_beat);
    chk("incr4_pulses", 32'(pulses), 32'd1);
    chk("incr4_beat", 32'(last_beat), 32'd4);

    // INCR8 from master0 with a 3-cycle stall before beat 5.
    run_burst(0, 3'd5, 8, 4, 3, pulses, last_beat);
    chk("incr8_pulses", 32'(pulses), 32'd1);
    chk("incr8_beat", 32'(last_beat), 32'd8);

    // WRAP16 to the last beat.
    run_burst(1, 3'd6, 16, 7, 1, pulses, last_beat);
    chk("wrap16_beat", 32'(last_beat), 32'd16);

    // Master0 INCR4, two-cycle ERROR on the data phase of beat 2.
    hgrant = 2'b01; hready_s = 1'b1; hresp_s = 1'b0; idle_all();
    tick();
    set_m(0, 2'd2, 3'd3, 32'h200);
    tick();
    set_m(0, 2'd3, 3'd3, 32'h204);
    tick();
    pulses = 0;
    set_m(0, 2'd3, 3'd3, 32'h208);
    hresp_s = 1'b1; hready_s = 1'b0;
    tick_chk();
    if (bl_seen) pulses++;
    chk("err1_hresp_m", 32'(hresp_m), 32'b01);
    chk("err1_htrans", 32'(htrans_s), 32'd0);
    tick_edge();
    hready_s = 1'b1;
    tick_chk();
    if (bl_seen) pulses++;
    chk("err2_hresp_m", 32'(hresp_m), 32'b01);
    chk("err2_htrans", 32'(htrans_s), 32'd0);
    tick_edge();
    hresp_s = 1'b0; idle_all();
    for (int k = 0; k < 3; k++) begin
      tick_chk();
      if (bl_seen) pulses++;
      tick_edge();
    end
    chk("err_no_last", 32'(pulses), 32'd0);

    // Multi-hot grant: sticky error, lowest master wins.
    set_m(0, 2'd2, 3'd0, 32'hC0C0_0000);
    set_m(1, 2'd2, 3'd0, 32'hC1C1_0000);
    hgrant = 2'b11;
    tick();
    tick_chk();
    chk("gerr_set", 32'(grant_err), 32'd1);
    chk("gerr_low_owner", haddr_s, 32'hC0C0_0000);
    tick_edge();
    hgrant = 2'b10; idle_all();
    tick(); tick();
    tick_chk();
    chk("gerr_sticky", 32'(grant_err), 32'd1);
    tick_edge();

    // Reset during beat 3 of INCR16 from master1.
    hgrant = 2'b10; idle_all();
    tick();
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      set_m(1, (b == 0) ? 2'd2 : 2'd3, 3'd7, 32'h3000 + 32'(b * 4));
      if (b == 2) hreset_n = 1'b0;
      tick_chk();
      if (bl_seen) pulses++;
      tick_edge();
    end
    hreset_n = 1'b1;
    tick_chk();
    chk("rst_haddr", haddr_s, 32'd0);
    chk("rst_htrans", 32'(htrans_s), 32'd0);
    chk("rst_hwdata", hwdata_s, 32'd0);
    chk("rst_gerr", 32'(grant_err), 32'd0);
    chk("rst_last", 32'(burst_last | (pulses != 0)), 32'd0);
    tick_edge();

    // Random phase: everything random, compared against the model each cycle.
    for (int c = 0; c < 400; c++) begin
      hreset_n = ($urandom_range(0, 49) != 0);
      hgrant   = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'b11;
      hready_s = ($urandom_range(0, 3) != 0);
      hresp_s  = ($urandom_range(0, 6) == 0);
      for (int i = 0; i < int'(MN); i++)
        set_m(i, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom());
      hwrite_m = 2'($urandom());
      hsize_m  = 6'($urandom());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
